mem_stream_reader: RTL and testbench

- Read-only bus master (initiator) on the mem_interface word bus. It is the counterpart of the SDRAM controller's slave port.
- Fetches a programmed block of 16-bit words from SDRAM as read bursts and buffers them in an internal FIFO.
- Presents the buffered words as a valid/ready stream to a consumer, e.g. video scanout or a DMA sink.
- Paces bursts by FIFO occupancy. Uses last4 so the controller can close a burst early.

---
 rtl/mem_pkg.sv | 13 +
 rtl/mem_interface.sv | 22 ++
 rtl/stream_fifo.sv | 71 +++++++
 rtl/mem_stream_reader.sv | 130 +++++++++++++
 tb/tb_mem_stream_reader.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared widths and the stream reader state encoding for the SDRAM word bus.
package mem_pkg;

  localparam int MEM_ADDR_W = 22;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PAUSE
  } reader_state_e;

endpackage

// File: rtl/mem_interface.sv
// Word-wide SDRAM access bus between the controller (slave) and its initiators.
interface mem_interface;

  logic                            request;
  logic [mem_pkg::MEM_ADDR_W-1:0]  address;
  logic                            write_enable;
  logic [mem_pkg::MEM_DATA_W-1:0]  data_write;
  logic                            last4;
  logic                            ready;
  logic [mem_pkg::MEM_DATA_W-1:0]  data_read;

  modport master (
    output request, address, write_enable, data_write, last4,
    input  ready, data_read
  );

  modport slave (
    input  request, address, write_enable, data_write, last4,
    output ready, data_read
  );

endinterface

// File: rtl/stream_fifo.sv
// Synchronous FIFO whose head word is held in a register, so data is valid as soon as the FIFO is non-empty.
module stream_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !flush;
    do_pop   = pop && !flush && (count_q != '0);
    wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, do_pop};
    count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    head_d   = head_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (do_pop && (count_q > (AW+1)'(1))) begin
      // Second-oldest entry becomes the head; it is already in memory even if pushed this cycle.
      head_d = mem[rd_ptr_q + AW'(1)];
    end else if (do_push && ((count_q == '0) || do_pop)) begin
      head_d = push_data;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign head_data = head_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/mem_stream_reader.sv
// Read-only SDRAM bus master: fetches a block of words as bursts, buffers them and streams them out.
module mem_stream_reader
  import mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [MEM_ADDR_W-1:0]  base_address,
  input  logic [LEN_W-1:0]       length,
  output logic                   busy,
  output logic                   done,
  output logic [MEM_DATA_W-1:0]  out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  mem_interface.master           data_bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  reader_state_e         state_q, state_d;
  logic [MEM_ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]      remaining_q, remaining_d;
  logic                  request_q, request_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  xfer, pop;
  logic [CW-1:0]         count, count_after, free_after;
  logic                  empty, full;

  // Abort discards any handshake in its own cycle.
  assign xfer = request_q && data_bus.ready && !abort;
  assign pop  = !empty && out_ready;

  always_comb begin
    count_after = abort ? '0 : count + CW'(xfer) - CW'(pop);
    free_after  = CW'(FIFO_DEPTH) - count_after;
    state_d     = state_q;
    addr_d      = addr_q + MEM_ADDR_W'(xfer);
    remaining_d = remaining_q - LEN_W'(xfer);
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d      = base_address;
            remaining_d = length;
            busy_d      = 1'b1;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        if (remaining_d == '0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (free_after < CW'(2)) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (free_after >= CW'(FIFO_DEPTH / 2)) begin
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      remaining_d = '0;
      done_d      = (state_q != IDLE);
    end
    // Two free slots cover the word that may still land in the cycle request falls.
    request_d = (state_d == FETCH) && (remaining_d != '0) && (free_after >= CW'(2));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      request_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      request_q   <= request_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (MEM_DATA_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (abort),
    .push      (xfer),
    .push_data (data_bus.data_read),
    .pop       (pop),
    .head_data (out_data),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  push_on_full_a: assert property (@(posedge clock) disable iff (reset) !(xfer && full));

  assign busy                  = busy_q;
  assign done                  = done_q;
  assign out_valid             = !empty;
  assign data_bus.request      = request_q;
  assign data_bus.address      = addr_q;
  assign data_bus.last4        = request_q && (remaining_q <= LEN_W'(4));
  assign data_bus.write_enable = 1'b0;
  assign data_bus.data_write   = '0;

endmodule

// File: tb/tb_mem_stream_reader.sv
// Randomized bench: memory returns address[15:0]; expected stream is base+k for each block.
module tb_mem_stream_reader;

  localparam int DEPTH = 16;
  localparam int LEN_W = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        start, abort, out_ready, mem_ready;
  logic [21:0] base_address;
  logic [LEN_W-1:0] length;
  logic        busy, done, out_valid;
  logic [15:0] out_data;
  int          n_checks = 0;
  int          n_pass = 0;

  mem_interface bus ();
  assign bus.ready     = mem_ready;
  assign bus.data_read = bus.address[15:0];

  always #5 clock = ~clock;

  mem_stream_reader #(
    .FIFO_DEPTH (DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .base_address (base_address),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .data_bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      chk({tag, ":idle_req"}, bus.request, 1'b0);
      chk({tag, ":idle_done"}, done, 1'b0);
    end
  endtask

  // Runs one block fetch; entered and left at posedge+1.
  task automatic run_fetch(input string tag, input logic [21:0] base, input int len,
                           input int rdy_pct, input int ord_pct, input int hold, input int abort_at);
    int xfers = 0, pops = 0, dones = 0, occ = 0, max_occ = 0, last_xfer_cyc = -100;
    bit aborted = 0, prev_req = 0, ended = 0;
    logic [21:0] a;
    start = 1'b1; abort = 1'b0; base_address = base; length = LEN_W'(len);
    mem_ready = 1'b0; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, ":busy_start"}, busy, len != 0);
    if (len == 0) begin
      chk({tag, ":zero_done"}, done, 1'b1);
      chk({tag, ":zero_req"}, bus.request, 1'b0);
      idle_cycles(tag, 3);
      $display("run %s base=%06h len=0", tag, base);
      return;
    end
    for (int cyc = 0; cyc < 3000 && !ended; cyc++) begin
      mem_ready = ($urandom_range(0, 99) < rdy_pct);
      out_ready = (cyc >= hold) && ($urandom_range(0, 99) < ord_pct);
      abort = (abort_at >= 0) && (xfers == abort_at) && !aborted;
      if (abort) out_ready = 1'b0;
      start = busy && !abort && !aborted && (cyc % 7 == 3);
      base_address = ~base; length = LEN_W'(3);
      #1;
      if (aborted) begin
        chk({tag, ":abort_req"}, bus.request, 1'b0);
        chk({tag, ":abort_valid"}, out_valid, 1'b0);
        chk({tag, ":abort_done"}, done, 1'b1);
        chk({tag, ":abort_busy"}, busy, 1'b0);
        ended = 1;
      end else begin
        occ = xfers - pops;
        chk({tag, ":last4"}, bus.last4, bus.request && ((len - xfers) <= 4));
        if (bus.request) begin
          a = base + 22'(xfers);
          chk({tag, ":addr"}, bus.address, a);
          chk({tag, ":req_in_range"}, xfers < len, 1'b1);
          if (!prev_req && xfers > 0) chk({tag, ":resume_occ"}, occ <= DEPTH / 2, 1'b1);
        end
        if (hold > 0 && cyc == hold - 1) chk({tag, ":bp_paused"}, bus.request, 1'b0);
        if (done) begin
          dones++;
          chk({tag, ":done_timing"}, cyc, last_xfer_cyc + 1);
          chk({tag, ":done_count"}, xfers, len);
          chk({tag, ":done_busy"}, busy, 1'b0);
        end
        if (out_valid && out_ready) begin
          a = base + 22'(pops);
          chk({tag, ":data"}, out_data, a[15:0]);
          pops++;
        end
        if (abort) aborted = 1;
        else if (bus.request && mem_ready) begin
          xfers++;
          last_xfer_cyc = cyc;
        end
        occ = xfers - pops;
        if (occ > max_occ) max_occ = occ;
        prev_req = bus.request;
        if (dones > 0 && pops == len) ended = 1;
      end
      @(posedge clock); #1;
    end
    start = 1'b0; abort = 1'b0; out_ready = 1'b0; mem_ready = 1'b0;
    chk({tag, ":finished"}, ended, 1'b1);
    if (!aborted) begin
      chk({tag, ":one_done"}, dones, 1);
      chk({tag, ":all_popped"}, pops, len);
      chk({tag, ":end_busy"}, busy, 1'b0);
      chk({tag, ":max_occ"}, max_occ <= DEPTH - 1, 1'b1);
    end
    $display("run %s base=%06h len=%0d xfers=%0d pops=%0d max_occ=%0d aborted=%0d",
             tag, base, len, xfers, pops, max_occ, aborted);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0; mem_ready = 1'b0;
    base_address = '0; length = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    chk("rst:req", bus.request, 1'b0);
    chk("rst:busy", busy, 1'b0);
    chk("rst:done", done, 1'b0);
    chk("rst:valid", out_valid, 1'b0);
    chk("rst:addr", bus.address, 22'h0);
    chk("rst:we", bus.write_enable, 1'b0);
    chk("rst:wdata", bus.data_write, 16'h0);
    @(posedge clock); #1;

    run_fetch("basic", 22'h000100, 8, 100, 100, 0, -1);
    run_fetch("backpressure", 22'h012340, 40, 100, 100, 60, -1);
    run_fetch("page_wrap", 22'h0000FC, 8, 60, 100, 0, -1);
    run_fetch("zero_len", 22'h000055, 0, 100, 100, 0, -1);
    run_fetch("abort", 22'h001000, 100, 100, 70, 0, 10);
    run_fetch("after_abort", 22'h000200, 4, 100, 100, 0, -1);

    start = 1'b1; abort = 1'b1; base_address = 22'h000300; length = LEN_W'(5);
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    chk("start_abort:busy", busy, 1'b0);
    chk("start_abort:done", done, 1'b0);
    idle_cycles("start_abort", 3);

    run_fetch("addr_wrap", 22'h3FFFF8, 20, 70, 80, 0, -1);
    for (int r = 0; r < 6; r++) begin
      run_fetch($sformatf("rand%0d", r), 22'($urandom), $urandom_range(1, 60),
                $urandom_range(30, 100), $urandom_range(20, 100), 0, -1);
    end

    start = 1'b1; base_address = 22'h001234; length = LEN_W'(50);
    mem_ready = 1'b1; out_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #1;
    chk("areset:pre_req", bus.request, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("areset:req", bus.request, 1'b0);
    chk("areset:busy", busy, 1'b0);
    chk("areset:valid", out_valid, 1'b0);
    mem_ready = 1'b0;
    @(posedge clock);
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #1;
    chk("areset:idle_busy", busy, 1'b0);
    chk("areset:idle_addr", bus.address, 22'h0);
    run_fetch("post_reset", 22'h002000, 12, 80, 90, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
